data_mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer that shares the single-port data memory between two requesters.
- Port 0 is the CPU load/store path; port 1 is the test/DMA loader.
- Each request is latched, driven onto the memory for one ACCESS cycle, then answered with a one-cycle ack. Read data is registered.
- Round-robin fairness; word-misaligned requests are rejected without touching memory.

---
 rtl/data_mem_arbiter.sv | 117 +++++++++++
 tb/tb_data_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that shares one single-port data memory between the CPU
// load/store path (port 0) and the test/DMA loader (port 1).
module data_mem_arbiter #(
    parameter int word_len = 32,
    parameter int addr_len = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [addr_len-1:0] m0_addr,
    input  logic [word_len-1:0] m0_wdata,
    output logic                m0_ack,
    output logic                m0_err,
    output logic [word_len-1:0] m0_rdata,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [addr_len-1:0] m1_addr,
    input  logic [word_len-1:0] m1_wdata,
    output logic                m1_ack,
    output logic                m1_err,
    output logic [word_len-1:0] m1_rdata,
    output logic [addr_len-1:0] mem_address,
    output logic [word_len-1:0] mem_write_bus,
    output logic                mem_write_en,
    output logic                mem_read_en,
    input  logic [word_len-1:0] mem_out_bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]          state;
    logic [addr_len-1:0] addr_q;
    logic [word_len-1:0] wdata_q;
    logic [word_len-1:0] rdata_q;
    logic                we_q;
    logic                err_q;
    logic                owner_q;
    logic                last_q;

    logic                any_req;
    logic                winner;
    logic                sel_we;
    logic [addr_len-1:0] sel_addr;
    logic [word_len-1:0] sel_wdata;

    // On a tie the port that was not served last wins, so grants alternate.
    always_comb begin
        any_req = m0_req | m1_req;
        winner  = 1'b0;
        if (m0_req && m1_req) begin
            winner = ~last_q;
        end else if (m1_req) begin
            winner = 1'b1;
        end
        sel_we    = winner ? m1_we    : m0_we;
        sel_addr  = winner ? m1_addr  : m0_addr;
        sel_wdata = winner ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        we_q    <= sel_we;
                        owner_q <= winner;
                        last_q  <= winner;
                        err_q   <= (sel_addr[1:0] != 2'b00);
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q && !err_q) begin
                        rdata_q <= mem_out_bus;
                    end
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Enables decode straight from state, so an async reset drops them at once
    // and an in-flight write never reaches the memory.
    always_comb begin
        mem_address   = addr_q;
        mem_write_bus = wdata_q;
        mem_write_en  = (state == ACCESS) && !err_q && we_q;
        mem_read_en   = (state == ACCESS) && !err_q && !we_q;
        m0_ack        = (state == RESP) && !owner_q;
        m1_ack        = (state == RESP) && owner_q;
        m0_err        = m0_ack && err_q;
        m1_err        = m1_ack && err_q;
        m0_rdata      = rdata_q;
        m1_rdata      = rdata_q;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: drivers push expected responses,
// a negedge monitor pops and compares them as acks appear.
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem_address, mem_write_bus, mem_out_bus;
    logic        mem_write_en, mem_read_en;

    data_mem_arbiter #(.word_len(32), .addr_len(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_address(mem_address), .mem_write_bus(mem_write_bus),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_out_bus(mem_out_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical memory seen by the DUT, plus a backdoor write port for preload.
    logic [31:0] mem [0:1023];
    logic        tb_wr;
    logic [9:0]  tb_wr_idx;
    logic [31:0] tb_wr_data;
    assign mem_out_bus = mem[mem_address[11:2]];
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_address[11:2]] <= mem_write_bus;
        else if (tb_wr)   mem[tb_wr_idx] <= tb_wr_data;
    end

    // Reference model: word array updated in request order per port.
    logic [31:0] ref_mem [0:1023];

    typedef struct {
        bit          we;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          ack_port[$];
    int          ack_cycle[$];
    int          cycle = 0;
    int          rd_en_cnt = 0;
    int          wr_en_cnt = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_rdata = 32'h0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: pops the expected response of whichever port acks.
    always @(negedge clk) begin
        exp_t e;
        int   p;
        if (!rst_n) begin
            exp_rdata = 32'h0;
        end else begin
            if (mem_read_en) rd_en_cnt++;
            if (mem_write_en) wr_en_cnt++;
            if (mem_read_en || mem_write_en)
                checkOutput("enable_aligned", {62'h0, mem_address[1:0]}, 64'h0);
            if (m0_ack || m1_ack) begin
                checkOutput("one_ack_only", {63'h0, m0_ack & m1_ack}, 64'h0);
                if (ack_cycle.size() > 0)
                    checkOutput("ack_spacing_ge3", {63'h0, (cycle - ack_cycle[$]) >= 3}, 64'h1);
                p = m1_ack ? 1 : 0;
                ack_port.push_back(p);
                ack_cycle.push_back(cycle);
                if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_ack: port %0d acked, expected no ack", p);
                end else begin
                    e = (p == 0) ? q0.pop_front() : q1.pop_front();
                    if (!e.we && !e.err) exp_rdata = e.rdata;
                    checkOutput("ack_err", {63'h0, (p == 0) ? m0_err : m1_err}, {63'h0, e.err});
                    checkOutput("ack_rdata", {32'h0, (p == 0) ? m0_rdata : m1_rdata}, {32'h0, exp_rdata});
                end
            end
        end
    end

    task automatic backdoorWrite(input int idx, input logic [31:0] val);
        tb_wr      = 1'b1;
        tb_wr_idx  = idx[9:0];
        tb_wr_data = val;
        ref_mem[idx] = val;
        @(posedge clk);
        @(negedge clk);
        tb_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Issues one request on port p (called at a negedge) and returns the
    // number of rising edges until its ack is visible.
    task automatic applyStimulus(input int p, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, output int lat);
        exp_t e;
        bit   got;
        e.we    = we;
        e.err   = (addr[1:0] != 2'b00);
        e.rdata = ref_mem[addr[11:2]];
        if (we && !e.err) ref_mem[addr[11:2]] = wdata;
        if (p == 0) begin
            q0.push_back(e);
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            q1.push_back(e);
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            got = (p == 0) ? m0_ack : m1_ack;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL ack_timeout: port %0d got no ack, expected ack within 30 cycles", p);
        end
        if (p == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
    endtask

    initial begin
        int lat;
        int rd0, wr0;
        logic [31:0] w250, w251;

        rst_n = 1'b0;
        tb_wr = 1'b0; tb_wr_idx = '0; tb_wr_data = '0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) backdoorWrite(i, $urandom);

        $display("[TB] reset state");
        checkOutput("rst_mem_address", {32'h0, mem_address}, 64'h0);
        checkOutput("rst_enables", {62'h0, mem_write_en, mem_read_en}, 64'h0);
        checkOutput("rst_acks", {62'h0, m0_ack, m1_ack}, 64'h0);
        checkOutput("rst_rdata", {32'h0, m0_rdata}, 64'h0);

        $display("[TB] contention from reset");
        ack_port.delete(); ack_cycle.delete();
        fork
            begin
                int l;
                for (int i = 0; i < 4; i++) applyStimulus(0, 0, 32'd2048 + 4 * i, 0, l);
            end
            begin
                int l;
                for (int i = 0; i < 4; i++) applyStimulus(1, 1, 32'd3072 + 4 * i, $urandom, l);
            end
            rst_n = 1'b1;
        join
        idle(2);
        checkOutput("contend_count", ack_port.size(), 8);
        for (int i = 0; i < ack_port.size(); i++) begin
            checkOutput("contend_order", ack_port[i], i % 2);
            if (i > 0) checkOutput("contend_spacing", ack_cycle[i] - ack_cycle[i-1], 3);
        end

        $display("[TB] port 0 read");
        backdoorWrite(250, 32'hDEADBEEF);
        backdoorWrite(252, 32'hAAAAAAAA);
        rd0 = rd_en_cnt; wr0 = wr_en_cnt;
        ack_port.delete(); ack_cycle.delete();
        applyStimulus(0, 0, 32'd1000, 32'h0, lat);
        idle(2);
        checkOutput("t1_latency", lat, 2);
        checkOutput("t1_read_en_cycles", rd_en_cnt - rd0, 1);
        checkOutput("t1_write_en_cycles", wr_en_cnt - wr0, 0);
        checkOutput("t1_acking_port", (ack_port.size() == 1) ? ack_port[0] : -1, 0);
        checkOutput("t1_rdata_direct", {32'h0, m0_rdata}, 64'hDEADBEEF);

        $display("[TB] port 1 write then read");
        wr0 = wr_en_cnt;
        applyStimulus(1, 1, 32'd1004, 32'h12345678, lat);
        checkOutput("t2_write_latency", lat, 2);
        applyStimulus(1, 0, 32'd1004, 32'h0, lat);
        checkOutput("t2_read_latency", lat, 3);
        idle(2);
        checkOutput("t2_write_en_cycles", wr_en_cnt - wr0, 1);
        checkOutput("t2_mem_word", {32'h0, mem[251]}, 64'h12345678);

        $display("[TB] misaligned write");
        rd0 = rd_en_cnt; wr0 = wr_en_cnt;
        w250 = mem[250]; w251 = mem[251];
        applyStimulus(0, 1, 32'd1002, 32'hFFFFFFFF, lat);
        idle(2);
        checkOutput("t4_no_enables", (rd_en_cnt - rd0) + (wr_en_cnt - wr0), 0);
        checkOutput("t4_word_1000", {32'h0, w250}, 64'hDEADBEEF);
        checkOutput("t4_word_1000_after", {32'h0, mem[250]}, 64'hDEADBEEF);
        checkOutput("t4_word_1004_after", {32'h0, mem[251]}, 64'h12345678);
        checkOutput("t4_rdata_held", {32'h0, m0_rdata}, 64'h12345678);

        $display("[TB] back-to-back reads");
        ack_port.delete(); ack_cycle.delete();
        applyStimulus(0, 0, 32'd1000, 0, lat);
        checkOutput("t6_first_latency", lat, 2);
        applyStimulus(0, 0, 32'd1004, 0, lat);
        applyStimulus(0, 0, 32'd1008, 0, lat);
        idle(2);
        checkOutput("t6_ack_count", ack_cycle.size(), 3);
        if (ack_cycle.size() == 3) begin
            checkOutput("t6_gap1", ack_cycle[1] - ack_cycle[0], 3);
            checkOutput("t6_gap2", ack_cycle[2] - ack_cycle[1], 3);
        end

        $display("[TB] reset during write access");
        ack_port.delete(); ack_cycle.delete();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd1008; m0_wdata = 32'h55555555;
        @(posedge clk);
        #1;
        checkOutput("t5_wr_en_before", {63'h0, mem_write_en}, 64'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_wr_en_dropped", {63'h0, mem_write_en}, 64'h0);
        checkOutput("t5_rd_en", {63'h0, mem_read_en}, 64'h0);
        checkOutput("t5_address", {32'h0, mem_address}, 64'h0);
        checkOutput("t5_write_bus", {32'h0, mem_write_bus}, 64'h0);
        checkOutput("t5_rdata", {32'h0, m0_rdata}, 64'h0);
        m0_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t5_word_kept", {32'h0, mem[252]}, 64'hAAAAAAAA);
        rst_n = 1'b1;
        idle(3);
        checkOutput("t5_no_ack", ack_cycle.size(), 0);

        $display("[TB] randomized traffic");
        fork
            begin
                int l;
                for (int i = 0; i < 25; i++) begin
                    logic [31:0] a;
                    a = 32'd2048 + 4 * ($urandom % 256);
                    if ($urandom % 8 == 0) a = a + 1 + ($urandom % 3);
                    applyStimulus(0, 1'($urandom % 2), a, $urandom, l);
                    idle($urandom % 3);
                end
            end
            begin
                int l;
                for (int i = 0; i < 25; i++) begin
                    logic [31:0] a;
                    a = 32'd3072 + 4 * ($urandom % 256);
                    if ($urandom % 8 == 0) a = a + 1 + ($urandom % 3);
                    applyStimulus(1, 1'($urandom % 2), a, $urandom, l);
                    idle($urandom % 3);
                end
            end
        join
        idle(4);
        checkOutput("scoreboard_drained", q0.size() + q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
